div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 start  in  1  division request, level-held by the requester until done is seen.
REQ-004 b_zero  in  1  divisor operand equals 0, valid whenever start=1.
REQ-005 r_ge_b  in  1  datapath comparator output, high when remainder register >= divisor register.
REQ-006 r_sclr, r_sl, r_e  out  1 each  remainder shift-register controls: clear, load/shift select, enable; the shift-in bit is A[3].
REQ-007 a_sl, a_e, a_w  out  1 each  dividend/quotient shift-register controls: load/shift select, enable, shift-in bit.
REQ-008 b_e  out  1  divisor register load enable.
REQ-009 busy, done, err  out  1 each  operation in progress, result valid, divide-by-zero flag.

Function
REQ-010 States SHALL be IDLE, SHIFT, SUB, DONE; 2-bit iteration counter cnt; 1-bit registered err.
REQ-011 IDLE with start=1 and b_zero=0: r_sclr=1, r_e=1, a_sl=1, a_e=1, b_e=1, cnt<=3, next SHIFT.
REQ-012 IDLE with start=1 and b_zero=1: no register enables, err<=1, next DONE.
REQ-013 IDLE with start=0: all enables 0, state held, result registers untouched.
REQ-014 In SHIFT, r_e=1 and r_sl=0 (R shifts in A[3]), and all A/B enables are 0; next SUB.
REQ-015 In SUB, a_e=1, a_sl=0, a_w=r_ge_b; if r_ge_b=1 then r_e=1, r_sl=1 (R<=R-B), else r_e=0.
REQ-016 In SUB, if cnt=0 the next state SHALL be DONE, else cnt<=cnt-1 and next SHIFT.
REQ-017 Latency: DONE SHALL be entered exactly 9 rising edges after the edge that samples start in IDLE (4 iterations x 2 cycles + load).
REQ-018 busy SHALL be 1 in SHIFT and SUB only; done SHALL be 1 in DONE only; err SHALL be output directly from its register.
REQ-019 DONE SHALL hold, with all enables 0, while start=1, and SHALL go to IDLE on the first cycle with start=0.
REQ-020 err SHALL clear on the next accepted start with b_zero=0 (IDLE load cycle).
REQ-021 start changes during SHIFT or SUB SHALL be ignored; there is no abort.
REQ-022 All outputs SHALL be Moore or Moore-plus-input combinational decodes; no output depends on r_ge_b except a_w, r_e and r_sl in SUB.
REQ-023 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-024 reset=1 SHALL force IDLE, cnt=0, err=0 immediately; all outputs 0 while reset is held.
REQ-025 Reset mid-operation SHALL abandon the division; datapath contents are don't-care afterwards, and the next start restarts cleanly.

Structure
REQ-026 Shared package div_pkg SHALL hold the state enum, N_BITS=4, and CNT_W=2.
REQ-027 The block SHALL be a single module (FSM plus inline counter) with no sub-module; the datapath (two shift registers, divisor register, 4-bit subtractor/comparator) is instantiated by the parent.

Verification
REQ-028 The bench SHALL wrap div_ctrl with a behavioural datapath (4-bit R and A shift registers, B register, subtractor) and check A and R at done.
REQ-029 A=13, B=4, start held -> done rises 9 edges after start is sampled; A=3, R=1, err=0.
REQ-030 A=15, B=1 -> A=15, R=0; a_w sequence over the 4 SUB cycles = 1,1,1,1.
REQ-031 A=7, B=9 -> A=0, R=7; r_e never high in SUB.
REQ-032 B=0, start=1 -> DONE on next edge, err=1, A and R unchanged; the next start with B=3, A=9 -> err=0, A=3, R=0.
REQ-033 reset pulsed during the 2nd SUB cycle -> immediately IDLE with busy=0, done=0; a following 13/4 run passes; start held 5 cycles in DONE keeps done=1 until start drops.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the 4-bit restoring-division controller.
// The datapath and its wrappers import this package as well.
package div_pkg;

  localparam int N_BITS = 4;
  localparam int CNT_W  = 2;

  // One SHIFT/SUB pair per quotient bit; the counter runs N_BITS-1 down to 0.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_SUB   = 2'd2,
    S_DONE  = 2'd3
  } div_state_e;

  typedef struct packed {
    logic r_sclr;
    logic r_sl;
    logic r_e;
    logic a_sl;
    logic a_e;
    logic a_w;
    logic b_e;
    logic busy;
    logic done;
  } div_ctrl_t;

  localparam div_ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/div_ctrl.sv
// Control FSM for a 4-bit restoring divider: sequences the external R/A/B
// registers through one load cycle and four SHIFT/SUB iterations.
module div_ctrl
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             b_zero,
  input  logic             r_ge_b,
  output logic             r_sclr,
  output logic             r_sl,
  output logic             r_e,
  output logic             a_sl,
  output logic             a_e,
  output logic             a_w,
  output logic             b_e,
  output logic             busy,
  output logic             done,
  output logic             err,
  output div_state_e       dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  // Handshake: the requester raises start and holds it until it sees done;
  // done stays high while start stays high, and the FSM returns to IDLE on
  // the first cycle start is low. start is ignored while busy (no abort).

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  div_ctrl_t        ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (b_zero) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            cnt_d   = CNT_INIT;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: state_d = S_SUB;
      S_SUB: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl = CTRL_NONE;
    case (state_q)
      S_IDLE: begin
        if (start && !b_zero) begin
          ctrl.r_sclr = 1'b1;
          ctrl.r_e    = 1'b1;
          ctrl.a_sl   = 1'b1;
          ctrl.a_e    = 1'b1;
          ctrl.b_e    = 1'b1;
        end
      end
      S_SHIFT: begin
        ctrl.busy = 1'b1;
        ctrl.r_e  = 1'b1;
      end
      S_SUB: begin
        // Quotient bit and the restore decision both come from the comparator.
        ctrl.busy = 1'b1;
        ctrl.a_e  = 1'b1;
        ctrl.a_w  = r_ge_b;
        ctrl.r_e  = r_ge_b;
        ctrl.r_sl = r_ge_b;
      end
      S_DONE: ctrl.done = 1'b1;
      default: ctrl = CTRL_NONE;
    endcase
  end

  // Outputs are forced low for as long as reset is asserted.
  div_ctrl_t ctrl_out;
  assign ctrl_out  = reset ? CTRL_NONE : ctrl;

  assign r_sclr    = ctrl_out.r_sclr;
  assign r_sl      = ctrl_out.r_sl;
  assign r_e       = ctrl_out.r_e;
  assign a_sl      = ctrl_out.a_sl;
  assign a_e       = ctrl_out.a_e;
  assign a_w       = ctrl_out.a_w;
  assign b_e       = ctrl_out.b_e;
  assign busy      = ctrl_out.busy;
  assign done      = ctrl_out.done;
  assign err       = err_q;
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: wraps it with a behavioural 4-bit divider datapath and
// checks quotient, remainder, err, latency and per-iteration decisions.
module tb_div_ctrl;
  import div_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [3:0] a_in, b_in;
  logic b_zero, r_ge_b;
  logic r_sclr, r_sl, r_e, a_sl, a_e, a_w, b_e, busy, done, err;
  div_state_e dbg_state;
  logic [CNT_W-1:0] dbg_cnt;

  logic [3:0] dp_a = 4'd0;
  logic [3:0] dp_r = 4'd0;
  logic [3:0] dp_b = 4'd0;

  int n_checks = 0;
  int n_fail = 0;

  // {err, A, R, quotient bits}
  logic [12:0] exp_q[$];
  logic [1:0]  sub_log[$];   // {a_w, r_e} sampled in each SUB cycle

  logic [3:0] m_a = 4'd0;
  logic [3:0] m_r = 4'd0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUT + datapath ----------------
  div_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .b_zero(b_zero), .r_ge_b(r_ge_b),
    .r_sclr(r_sclr), .r_sl(r_sl), .r_e(r_e), .a_sl(a_sl), .a_e(a_e), .a_w(a_w),
    .b_e(b_e), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  assign b_zero = (b_in == 4'd0);
  assign r_ge_b = (dp_r >= dp_b);

  always @(posedge clk) begin
    if (b_e) dp_b <= b_in;
    if (a_e) dp_a <= a_sl ? a_in : {dp_a[2:0], a_w};
    if (r_e) dp_r <= r_sclr ? 4'd0 : (r_sl ? dp_r - dp_b : {dp_r[2:0], dp_a[3]});
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic done_prev = 1'b0;
  always @(posedge clk) begin
    logic [12:0] e;
    logic [3:0]  aw_bits, re_bits;
    #1;
    if (!reset && a_e && !a_sl) sub_log.push_back({a_w, r_e});
    if (!reset && done && !done_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("err_at_done", int'(err), int'(e[12]));
        check("a_at_done", int'(dp_a), int'(e[11:8]));
        check("r_at_done", int'(dp_r), int'(e[7:4]));
        if (e[12]) begin
          check("sub_cycles_div0", sub_log.size(), 0);
        end else begin
          check("sub_cycles", sub_log.size(), 4);
          if (sub_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
              aw_bits[3-i] = sub_log[i][1];
              re_bits[3-i] = sub_log[i][0];
            end
            check("a_w_sequence", int'(aw_bits), int'(e[3:0]));
            check("r_e_in_sub", int'(re_bits), int'(e[3:0]));
          end
        end
      end
      sub_log.delete();
    end
    done_prev = done;
  end

  // ---------------- driver ----------------
  task automatic run_div(input logic [3:0] a, input logic [3:0] b, input int hold);
    int edges, exp_lat;
    logic seen, busy_ok, held_ok;
    logic [3:0] q, ea, er;
    logic e;
    if (b == 4'd0) begin
      e = 1'b1; q = 4'd0; ea = m_a; er = m_r; exp_lat = 1;
    end else begin
      e = 1'b0; q = a / b; ea = q; er = a % b; exp_lat = 9;
    end
    m_a = ea;
    m_r = er;
    exp_q.push_back({e, ea, er, q});
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    edges = 0; seen = 1'b0; busy_ok = 1'b1;
    // edges counts rising edges, the one sampling start being number 1
    while (!seen && edges < 40) begin
      @(posedge clk); edges++; #1;
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    check("latency", edges, seen ? exp_lat : -1);
    if (!seen) begin
      exp_q.delete();
    end else begin
      if (b != 4'd0) check("busy_while_running", int'(busy_ok), 1);
      held_ok = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!done) held_ok = 1'b0;
      end
      if (hold > 0) check("done_held", int'(held_ok), 1);
    end
    @(negedge clk);
    start = 1'b0;
    a_in = 4'($urandom);
    b_in = 4'($urandom);
    @(posedge clk); #1;
    check("return_idle", int'({done, busy}), 0);
  endtask

  task automatic idle_gap(input int n);
    repeat (n) @(negedge clk);
    if (n > 0) begin
      check("idle_a_kept", int'(dp_a), int'(m_a));
      check("idle_r_kept", int'(dp_r), int'(m_r));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pick;
    logic [3:0] ra, rb;
    reset = 1'b1; start = 1'b1; a_in = 4'd5; b_in = 4'd2;
    #2;
    check("reset_outputs",
          int'({r_sclr, r_sl, r_e, a_sl, a_e, a_w, b_e, busy, done, err}), 0);
    check("reset_state", int'(dbg_state), int'(S_IDLE));
    check("reset_cnt", int'(dbg_cnt), 0);
    @(negedge clk); @(negedge clk);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);

    run_div(4'd13, 4'd4, 0);
    run_div(4'd15, 4'd1, 0);
    run_div(4'd7,  4'd9, 0);
    run_div(4'd11, 4'd0, 0);
    check("err_after_div0", int'(err), 1);
    run_div(4'd9,  4'd3, 0);
    check("err_cleared", int'(err), 0);

    // reset in the second SUB cycle of a 13/4 run
    exp_q.push_back(13'd0);
    @(negedge clk);
    a_in = 4'd13; b_in = 4'd4; start = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_busy_done", int'({busy, done}), 0);
    check("midreset_state", int'(dbg_state), int'(S_IDLE));
    check("midreset_enables", int'({r_sclr, r_e, a_e, b_e}), 0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    exp_q.delete();
    sub_log.delete();
    run_div(4'd13, 4'd4, 5);

    for (int i = 0; i < 25; i++) begin
      pick = $urandom_range(0, 5);
      ra = 4'($urandom_range(0, 15));
      rb = (pick == 0) ? 4'd0 : 4'($urandom_range(1, 8));
      run_div(ra, rb, $urandom_range(0, 3));
      idle_gap($urandom_range(0, 3));
    end

    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
